// File: rtl/spi_regif_pkg.sv
// Shared constants and FSM state type for the SPI register interface.
package spi_regif_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_WDOG   = 3'd1;
  localparam logic [2:0] ADDR_CFG0   = 3'd2;
  localparam logic [2:0] ADDR_CFG1   = 3'd3;
  localparam logic [2:0] ADDR_CFG2   = 3'd4;
  localparam logic [2:0] ADDR_HWCFG  = 3'd5;
  localparam logic [2:0] ADDR_WDKICK = 3'd6;
  localparam logic [2:0] ADDR_RSVD   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_DONE
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage flop synchronizer for one asynchronous pin, with selectable reset value.
module spi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_regif.sv
// SPI mode-0 slave: decodes 16-bit frames into one-cycle register write strobes
// and serves readback busses on MISO, all in the clk domain.
module spi_regif
  import spi_regif_pkg::*;
#(
  parameter int          FRAME_BITS  = spi_regif_pkg::FRAME_BITS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       miso,
  output logic       misoen,
  input  logic [7:0] controlrdata,
  input  logic [7:0] hwconfig,
  input  logic [7:0] configrdreg0,
  input  logic [7:0] configrdreg1,
  input  logic [7:0] configrdreg2,
  output logic [7:0] wrtdata,
  output logic       ctrlld,
  output logic       wdogdivld,
  output logic       cfgld0,
  output logic       cfgld1,
  output logic       cfgld2,
  output logic       wdreset
);

  localparam logic [4:0] HDR_LAST   = 5'(FRAME_BITS / 2 - 1);
  localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS - 1);
  localparam logic [3:0] FLUSH_N    = 4'(SYNC_STAGES);

  logic       sclk_s, mosi_s, ss_s;
  logic       sclk_prev, ss_prev;
  logic       rise, fall;
  state_t     state;
  logic [4:0] cnt;
  logic [6:0] sr;
  logic       wr_frame;
  logic [2:0] addr;
  logic [7:0] tx;
  logic [2:0] hdr_addr;
  logic [7:0] rd_sel;
  logic [3:0] flush;
  logic       armed;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .d(ss_n), .q(ss_s)
  );

  assign rise     = sclk_s & ~sclk_prev;
  assign fall     = ~sclk_s & sclk_prev;
  assign misoen   = ~ss_s;
  assign hdr_addr = {sr[1:0], mosi_s};

  always_comb begin
    rd_sel = '0;
    case (hdr_addr)
      ADDR_CTRL:  rd_sel = controlrdata;
      ADDR_CFG0:  rd_sel = configrdreg0;
      ADDR_CFG1:  rd_sel = configrdreg1;
      ADDR_CFG2:  rd_sel = configrdreg2;
      ADDR_HWCFG: rd_sel = hwconfig;
      default:    rd_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sr        <= '0;
      wr_frame  <= 1'b0;
      addr      <= '0;
      tx        <= '0;
      miso      <= 1'b0;
      wrtdata   <= '0;
      ctrlld    <= 1'b0;
      wdogdivld <= 1'b0;
      cfgld0    <= 1'b0;
      cfgld1    <= 1'b0;
      cfgld2    <= 1'b0;
      wdreset   <= 1'b0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
      flush     <= '0;
      armed     <= 1'b0;
    end else begin
      ctrlld    <= 1'b0;
      wdogdivld <= 1'b0;
      cfgld0    <= 1'b0;
      cfgld1    <= 1'b0;
      cfgld2    <= 1'b0;
      wdreset   <= 1'b0;
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;

      // After reset the ss_n chain holds its reset value; only accept a frame once
      // the real pin has been seen high, so a frame in progress is not picked up midway.
      if (flush != FLUSH_N) begin
        flush <= flush + 4'd1;
      end else if (ss_s) begin
        armed <= 1'b1;
      end

      if (ss_s) begin
        state <= ST_IDLE;
        cnt   <= '0;
        miso  <= 1'b0;
        tx    <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (armed && ss_prev) begin
              state <= ST_HDR;
              cnt   <= '0;
              sr    <= '0;
              tx    <= '0;
              miso  <= 1'b0;
            end
          end
          ST_HDR: begin
            if (rise) begin
              sr  <= {sr[5:0], mosi_s};
              cnt <= cnt + 5'd1;
              if (cnt == HDR_LAST) begin
                state    <= ST_DATA;
                wr_frame <= sr[6];
                addr     <= hdr_addr;
                tx       <= sr[6] ? 8'h00 : rd_sel;
              end
            end
          end
          ST_DATA: begin
            if (rise) begin
              sr  <= {sr[5:0], mosi_s};
              cnt <= cnt + 5'd1;
              if (cnt == FRAME_LAST) begin
                state <= ST_DONE;
                if (wr_frame) begin
                  wrtdata <= {sr[6:0], mosi_s};
                  case (addr)
                    ADDR_CTRL:   ctrlld    <= 1'b1;
                    ADDR_WDOG:   wdogdivld <= 1'b1;
                    ADDR_CFG0:   cfgld0    <= 1'b1;
                    ADDR_CFG1:   cfgld1    <= 1'b1;
                    ADDR_CFG2:   cfgld2    <= 1'b1;
                    ADDR_WDKICK: wdreset   <= 1'b1;
                    default:     ;
                  endcase
                end
              end
            end
          end
          default: ;
        endcase

        if (fall && (state == ST_DATA || state == ST_DONE)) begin
          miso <= tx[7];
          tx   <= {tx[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_regif.sv
// Directed bench for spi_regif: table of SPI frames plus reset/latch corner sequences.
module tb_spi_regif;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
  logic       miso, misoen;
  logic [7:0] controlrdata = 8'h3C, hwconfig = 8'h5A;
  logic [7:0] configrdreg0 = 8'hC3, configrdreg1 = 8'h96, configrdreg2 = 8'hA5;
  logic [7:0] wrtdata;
  logic       ctrlld, wdogdivld, cfgld0, cfgld1, cfgld2, wdreset;

  int errors = 0;
  int checks = 0;
  int sc [6];
  logic [7:0] strobe_wrt = 8'h00;

  always #5 clk = ~clk;

  spi_regif #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .misoen(misoen),
    .controlrdata(controlrdata), .hwconfig(hwconfig),
    .configrdreg0(configrdreg0), .configrdreg1(configrdreg1), .configrdreg2(configrdreg2),
    .wrtdata(wrtdata), .ctrlld(ctrlld), .wdogdivld(wdogdivld),
    .cfgld0(cfgld0), .cfgld1(cfgld1), .cfgld2(cfgld2), .wdreset(wdreset)
  );

  initial for (int i = 0; i < 6; i++) sc[i] = 0;

  always @(negedge clk) begin
    if (ctrlld)    sc[0] = sc[0] + 1;
    if (wdogdivld) sc[1] = sc[1] + 1;
    if (cfgld0)    sc[2] = sc[2] + 1;
    if (cfgld1)    sc[3] = sc[3] + 1;
    if (cfgld2)    sc[4] = sc[4] + 1;
    if (wdreset)   sc[5] = sc[5] + 1;
    if (ctrlld | wdogdivld | cfgld0 | cfgld1 | cfgld2 | wdreset) strobe_wrt = wrtdata;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sends pat[n-1] first; captures miso at each sclk rise
  task automatic spi_bits(input logic [31:0] pat, input int n, output logic [31:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = pat[i];
      wait_clk(5);
      sclk = 1'b1;
      rx = {rx[30:0], miso};
      wait_clk(5);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] pat, input int n, output logic [31:0] rx);
    ss_n = 1'b0;
    wait_clk(6);
    check("misoen_in_frame", {31'b0, misoen}, 32'd1);
    spi_bits(pat, n, rx);
    wait_clk(6);
    ss_n = 1'b1;
    wait_clk(12);
  endtask

  function automatic logic [23:0] snap_counts(input int base [6]);
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v[i*4 +: 4] = 4'(sc[i] - base[i]);
    return v;
  endfunction

  function automatic logic [23:0] exp_counts(input logic [5:0] s);
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v[i*4] = s[i];
    return v;
  endfunction

  typedef struct {
    logic       w;
    logic [2:0] addr;
    logic [7:0] data;
    int         nbits;
    logic [5:0] strb;   // bit0 ctrl, 1 wdog, 2 cfg0, 3 cfg1, 4 cfg2, 5 wdreset
    logic [7:0] wrt;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [31:0] rx, pat;
    logic [15:0] frame;
    int base [6];

    vecs[0]  = '{1'b1, 3'd0, 8'h80, 16, 6'b000001, 8'h80, 8'h00};
    vecs[1]  = '{1'b1, 3'd3, 8'h35, 16, 6'b001000, 8'h35, 8'h00};
    vecs[2]  = '{1'b1, 3'd6, 8'h77, 16, 6'b100000, 8'h77, 8'h00};
    vecs[3]  = '{1'b0, 3'd4, 8'h00, 16, 6'b000000, 8'h77, 8'hA5};
    vecs[4]  = '{1'b1, 3'd2, 8'h44, 12, 6'b000000, 8'h77, 8'h00};
    vecs[5]  = '{1'b1, 3'd2, 8'h44, 16, 6'b000100, 8'h44, 8'h00};
    vecs[6]  = '{1'b1, 3'd1, 8'h11, 24, 6'b000010, 8'h11, 8'h00};
    vecs[7]  = '{1'b0, 3'd7, 8'hFF, 16, 6'b000000, 8'h11, 8'h00};
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 16, 6'b000000, 8'h11, 8'h3C};
    vecs[9]  = '{1'b0, 3'd5, 8'hFF, 16, 6'b000000, 8'h11, 8'h5A};
    vecs[10] = '{1'b0, 3'd1, 8'h00, 16, 6'b000000, 8'h11, 8'h00};
    vecs[11] = '{1'b1, 3'd4, 8'h5B, 16, 6'b010000, 8'h5B, 8'h00};
    vecs[12] = '{1'b0, 3'd2, 8'h00, 16, 6'b000000, 8'h5B, 8'hC3};
    vecs[13] = '{1'b0, 3'd3, 8'h00, 16, 6'b000000, 8'h5B, 8'h96};
    vecs[14] = '{1'b0, 3'd6, 8'h00, 16, 6'b000000, 8'h5B, 8'h00};

    wait_clk(3);
    check("rst_wrtdata", {24'b0, wrtdata}, 32'h0);
    check("rst_miso", {31'b0, miso}, 32'h0);
    check("rst_misoen", {31'b0, misoen}, 32'h0);
    check("rst_strobes", {26'b0, ctrlld, wdogdivld, cfgld0, cfgld1, cfgld2, wdreset}, 32'h0);
    rst_n = 1'b1;
    wait_clk(10);

    foreach (vecs[k]) begin
      base = sc;
      frame = {vecs[k].w, 4'b0000, vecs[k].addr, vecs[k].data};
      pat = {16'h0, frame};
      if (vecs[k].nbits == 24) pat = {8'h0, frame, 8'hAA};
      else if (vecs[k].nbits == 12) pat = {20'h0, frame[15:4]};
      spi_frame(pat, vecs[k].nbits, rx);
      check($sformatf("v%0d_strobes", k), {8'b0, snap_counts(base)}, {8'b0, exp_counts(vecs[k].strb)});
      check($sformatf("v%0d_wrtdata", k), {24'b0, wrtdata}, {24'b0, vecs[k].wrt});
      if (vecs[k].strb != 6'b0)
        check($sformatf("v%0d_wrt_at_strobe", k), {24'b0, strobe_wrt}, {24'b0, vecs[k].wrt});
      if (!vecs[k].w)
        check($sformatf("v%0d_readback", k), {24'b0, rx[7:0]}, {24'b0, vecs[k].rd});
      check($sformatf("v%0d_idle_misoen", k), {30'b0, misoen, miso}, 32'h0);
    end

    // readback must be captured at the 8th rise, not follow later bus changes
    ss_n = 1'b0;
    wait_clk(6);
    spi_bits(32'h04, 8, rx);
    configrdreg2 = 8'h00;
    spi_bits(32'h00, 8, rx);
    check("latch_once", {24'b0, rx[7:0]}, 32'hA5);
    wait_clk(6);
    ss_n = 1'b1;
    configrdreg2 = 8'hA5;
    wait_clk(12);

    // reset at bit 10 of a ctrl write; clocking the rest of the frame must not strobe
    base = sc;
    ss_n = 1'b0;
    wait_clk(6);
    spi_bits(32'h80FF >> 6, 10, rx);
    rst_n = 1'b0;
    #1;
    check("midrst_wrtdata", {24'b0, wrtdata}, 32'h0);
    check("midrst_misoen", {30'b0, misoen, miso}, 32'h0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    spi_bits(32'h3F, 6, rx);
    wait_clk(10);
    check("midrst_no_strobe", {8'b0, snap_counts(base)}, 32'h0);
    check("midrst_wrt_hold", {24'b0, wrtdata}, 32'h0);
    ss_n = 1'b1;
    wait_clk(12);
    spi_frame(32'h805E, 16, rx);
    check("post_rst_strobe", {8'b0, snap_counts(base)}, {8'b0, exp_counts(6'b000001)});
    check("post_rst_wrtdata", {24'b0, wrtdata}, 32'h5E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_regif.md
# spi_regif

SPI slave register interface that drives the host side of the motor control block. It decodes 16-bit SPI frames into one-cycle load strobes (`cfgld0..2`, `ctrlld`, `wdogdivld`) and a `wdreset` pulse, all accompanied by `wrtdata`. For reads, it muxes the control, config and hardware-config readback busses onto MISO. It sits between the board SPI pins and the control block, entirely in the `clk` domain.

## Interface
Parameters:
- `FRAME_BITS`, 16, bits per frame (fixed; no other value supported).
- `SYNC_STAGES`, 2, synchronizer depth on `sclk`, `mosi`, `ss_n`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sclk`, `mosi`, `ss_n`  in  1 each  raw SPI pins, mode 0, asynchronous to `clk`.
- `miso`  out  1  serial read data.
- `misoen`  out  1  MISO output enable; high while synchronized `ss_n` is low.
- `controlrdata`, `hwconfig`, `configrdreg0`, `configrdreg1`, `configrdreg2`  in  8 each  readback busses.
- `wrtdata`  out  8  write data; held until the next write.
- `ctrlld`, `wdogdivld`, `cfgld0`, `cfgld1`, `cfgld2`, `wdreset`  out  1 each  single-`clk` write strobes.

## Operation
- Frame format, MSB first:
  - byte 0: bit7 = W (1 = write, 0 = read); bits6:3 ignored; bits2:0 = address.
  - byte 1: write data on MOSI, or read data on MISO.
- Address map:
  - 0 = control (`ctrlld`, read `controlrdata`)
  - 1 = wdogdiv (`wdogdivld`, reads 0x00)
  - 2/3/4 = config0/1/2 (`cfgldN`, read `configrdregN`)
  - 5 = hwconfig (write ignored, read `hwconfig`)
  - 6 = watchdog kick (write pulses `wdreset`, data ignored, reads 0x00)
  - 7 = reserved (write ignored, reads 0x00)
- Edge detection uses synchronized `sclk` (previous vs current).
- FSM states:
  - IDLE: `ss_n` high.
  - HDR: bits 0–7.
  - DATA: bits 8–15.
  - DONE: bits beyond 16.
- Transitions:
  - IDLE→HDR on synchronized `ss_n` fall.
  - HDR→DATA on the 8th rise.
  - DATA→DONE on the 16th rise.
  - Any state→IDLE on synchronized `ss_n` rise.
- Bit counter is 5 bits and saturates at 16.
- MOSI is sampled on detected `sclk` rises.
- Write path, at the 16th rise when W=1:
  - `wrtdata` is loaded with byte 1.
  - The decoded strobe is high for exactly one `clk` on the following cycle.
  - `wrtdata` is stable before and during the strobe.
- Read path:
  - On the 8th rise, the selected readback bus is latched into the 8-bit TX shift register.
  - On the 8th fall, `miso` = TX[7]; each subsequent fall shifts left with 0 fill.
  - `miso` = 0 at all other times.
- DONE ignores further clocks: no second strobe until `ss_n` cycles high then low.
- Abort: `ss_n` rising before the 16th rise returns to IDLE with no strobe; `wrtdata` is unchanged.

## Timing
- Reset values: all strobes 0, `wrtdata` 0x00, `miso` 0, `misoen` 0, FSM IDLE, counters 0.
- Input latency: `SYNC_STAGES` + 1 `clk` from a pin change to the detected edge.
- Write latency: strobe asserts on the `clk` edge immediately after the cycle that detects the 16th rise.
- SCLK limits: max frequency `clk`/8; min high and low time 4 `clk` each.
- `ss_n` setup to the first `sclk` rise: ≥4 `clk`.
- `miso` changes ≤4 `clk` after each `sclk` fall, so it is valid before the next rise at the max SCLK rate.
- Readback latch is captured once per frame; bus changes after the 8th rise do not affect the frame.
- `rst_n` asserted mid-frame: immediate return to reset values; the frame is lost; the next frame starts only after a fresh `ss_n` fall.
- `ss_n` rise in the same `clk` as the 16th rise: the `ss_n` rise wins, so no strobe.

## Structure
- Shared package `spi_regif_pkg`:
  - address constants `ADDR_CTRL`..`ADDR_RSVD`
  - `FRAME_BITS`
  - FSM state enum
- Sub-module `spi_sync`: `SYNC_STAGES`-deep flop chain with async active-low reset to 1 (for `ss_n`) or 0 (for `sclk`/`mosi`) via a reset-value parameter. Instantiated three times.

## Test plan
- Write 0x80 to addr 0 → `ctrlld` high for exactly 1 `clk`, `wrtdata`=0x80 during the strobe; no other strobe.
- Write 0x35 to addr 3 → `cfgld1` pulse with `wrtdata`=0x35; then write to addr 6 → one `wdreset` pulse.
- Read addr 4 with `configrdreg2`=0xA5 → MISO bits 8–15 = 1,0,1,0,0,1,0,1; `misoen` high only during `ss_n` low.
- Abort: `ss_n` rises after 12 bits of a write to addr 2 → no `cfgld0`, `wrtdata` unchanged; next full frame works.
- 24-clock frame writing 0x11 to addr 1 → single `wdogdivld`, extra clocks ignored; read addr 7 returns 0x00.
- `rst_n` low mid-frame at bit 10 → all outputs at reset values, no strobe after release until a new frame.
